// File: rtl/branch_update_queue_pkg.sv
// Shared definitions for the branch update queue: default sizing and the
// layout of the packed {pc, taken, target} entry.
package branch_update_queue_pkg;

  localparam int BUQ_DEPTH_EXP2 = 3;
  localparam int BUQ_ADDR_WIDTH = 32;

  // Entry layout, lsb first: target, taken, pc
  function automatic int buq_entry_width(input int addr_width);
    return 2 * addr_width + 1;
  endfunction

  function automatic int buq_target_lsb(input int addr_width);
    return 0 * addr_width;
  endfunction

  function automatic int buq_taken_bit(input int addr_width);
    return addr_width;
  endfunction

  function automatic int buq_pc_lsb(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Execute-side push, predictor-side replay and performance-counter bundle
// of the branch update queue.
interface branch_update_queue_if #(
  parameter int ADDR_WIDTH = branch_update_queue_pkg::BUQ_ADDR_WIDTH
);
  logic                  ex_branch_valid_i;
  logic [ADDR_WIDTH-1:0] ex_branch_pc_i;
  logic                  ex_branch_taken_i;
  logic [ADDR_WIDTH-1:0] ex_branch_target_i;
  logic                  ex_predicted_taken_i;
  logic                  flush_i;
  logic                  update_ready_i;
  logic                  branch_valid_o;
  logic [ADDR_WIDTH-1:0] branch_pc_o;
  logic                  branch_taken_o;
  logic [ADDR_WIDTH-1:0] branch_target_address_o;
  logic                  full_o;
  logic [31:0]           perf_mispredict_counter;
  logic [31:0]           perf_drop_counter;

  modport master (
    output ex_branch_valid_i, ex_branch_pc_i, ex_branch_taken_i,
           ex_branch_target_i, ex_predicted_taken_i, flush_i, update_ready_i,
    input  branch_valid_o, branch_pc_o, branch_taken_o,
           branch_target_address_o, full_o, perf_mispredict_counter,
           perf_drop_counter
  );

  modport slave (
    input  ex_branch_valid_i, ex_branch_pc_i, ex_branch_taken_i,
           ex_branch_target_i, ex_predicted_taken_i, flush_i, update_ready_i,
    output branch_valid_o, branch_pc_o, branch_taken_o,
           branch_target_address_o, full_o, perf_mispredict_counter,
           perf_drop_counter
  );
endinterface

// File: rtl/branch_update_queue_fifo_mem.sv
// Entry storage for the branch update queue: one synchronous write port and
// one asynchronous read port. Contents are not reset; the top gates reads.
module buq_fifo_mem #(
  parameter int DEPTH_EXP2 = 3,
  parameter int WIDTH      = 65
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_EXP2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_EXP2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_EXP2];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_update_queue.sv
// Queues resolved branches from execute and replays them in program order to
// the predictor update port; also counts mispredictions and full-queue drops.
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH_EXP2 = BUQ_DEPTH_EXP2,
  parameter int ADDR_WIDTH = BUQ_ADDR_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  branch_update_queue_if.slave  bus
);

  localparam int PTR_W      = DEPTH_EXP2 + 1;
  localparam int ENTRY_W    = buq_entry_width(ADDR_WIDTH);
  localparam int PC_LSB     = buq_pc_lsb(ADDR_WIDTH);
  localparam int TAKEN_BIT  = buq_taken_bit(ADDR_WIDTH);
  localparam int TARGET_LSB = buq_target_lsb(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{DEPTH_EXP2{1'b0}}, 1'b1};

  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [31:0]           r_mispredict_cnt;
  logic [31:0]           r_drop_cnt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_deq;
  logic                  w_enq;
  logic                  w_drop;
  logic                  w_mispredict;
  logic [ENTRY_W-1:0]    w_wdata;
  logic [ENTRY_W-1:0]    w_rdata;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic                  w_head_taken;
  logic [ADDR_WIDTH-1:0] w_head_target;

  // Extra wrap bit distinguishes full from empty when the indices match
  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[DEPTH_EXP2-1:0] == r_wr_ptr[DEPTH_EXP2-1:0]) &&
                   (r_rd_ptr[DEPTH_EXP2] != r_wr_ptr[DEPTH_EXP2]);

  assign w_deq  = !w_empty && bus.update_ready_i && !bus.flush_i;
  assign w_enq  = bus.ex_branch_valid_i && (!w_full || w_deq) && !bus.flush_i;
  assign w_drop = bus.ex_branch_valid_i && w_full && !w_deq && !bus.flush_i;
  assign w_mispredict = w_enq && (bus.ex_predicted_taken_i != bus.ex_branch_taken_i);

  assign w_wdata = {bus.ex_branch_pc_i, bus.ex_branch_taken_i, bus.ex_branch_target_i};

  buq_fifo_mem #(
    .DEPTH_EXP2 (DEPTH_EXP2),
    .WIDTH      (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_enq),
    .i_waddr (r_wr_ptr[DEPTH_EXP2-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[DEPTH_EXP2-1:0]),
    .o_rdata (w_rdata)
  );

  // Head view; stale storage must not leak out while empty
  always_comb begin
    w_head_pc     = {ADDR_WIDTH{1'b0}};
    w_head_taken  = 1'b0;
    w_head_target = {ADDR_WIDTH{1'b0}};
    if (w_empty) begin
      w_head_pc     = {ADDR_WIDTH{1'b0}};
      w_head_taken  = 1'b0;
      w_head_target = {ADDR_WIDTH{1'b0}};
    end else begin
      w_head_pc     = w_rdata[PC_LSB +: ADDR_WIDTH];
      w_head_taken  = w_rdata[TAKEN_BIT];
      w_head_target = w_rdata[TARGET_LSB +: ADDR_WIDTH];
    end
  end

  // Pointer and counter update; flush collapses the write pointer onto the read pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr         <= {PTR_W{1'b0}};
      r_wr_ptr         <= {PTR_W{1'b0}};
      r_mispredict_cnt <= 32'd0;
      r_drop_cnt       <= 32'd0;
    end else begin
      if (bus.flush_i) begin
        r_wr_ptr <= r_rd_ptr;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
      if (w_mispredict) begin
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign bus.branch_valid_o          = !w_empty;
  assign bus.branch_pc_o             = w_head_pc;
  assign bus.branch_taken_o          = w_head_taken;
  assign bus.branch_target_address_o = w_head_target;
  assign bus.full_o                  = w_full;
  assign bus.perf_mispredict_counter = r_mispredict_cnt;
  assign bus.perf_drop_counter       = r_drop_cnt;

endmodule
